// File: rtl/scan_port_ctrl.sv
// rtl/scan_port_ctrl.sv - scan port protocol engine: strobe decode, array memory access, execution sequencing
module scan_port_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chip_en,
    input  logic [DATA_W-1:0] scan_data_in,
    input  logic              scan_data_or_addr,
    input  logic              read_write,
    input  logic [1:0]        data_addr_valid,
    input  logic              scan_start_exec,
    output logic [DATA_W-1:0] scan_data_out,
    output logic              scan_data_oe,
    output logic              data_out_valid,
    output logic              exec_end,
    output logic              scan_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              exec_run,
    input  logic              exec_done
);

    // Word index occupies the low 12 address bits; the bits above are the target select.
    localparam int IDX_W = 12;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_REQ   = 3'd1;
    localparam logic [2:0] ST_RD_REQ   = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_RD_HOLD  = 3'd4;
    localparam logic [2:0] ST_EXEC     = 3'd5;
    localparam logic [2:0] ST_EXEC_END = 3'd6;

    logic [2:0]        state;
    logic [1:0]        stb_sync;
    logic              stb_last;
    logic [1:0]        go_sync;
    logic              go_last;
    logic              stb;
    logic              go;
    logic              stb_lvl;
    logic              go_lvl;
    logic              burst_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_inc;

    // Bring the asynchronous host strobe and exec request into the clock domain and keep the last level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb_sync <= 2'b00;
            stb_last <= 1'b0;
            go_sync  <= 2'b00;
            go_last  <= 1'b0;
        end else begin
            stb_sync <= {stb_sync[0], data_addr_valid[0]};
            stb_last <= stb_sync[1];
            go_sync  <= {go_sync[0], scan_start_exec};
            go_last  <= go_sync[1];
        end
    end

    assign stb_lvl = stb_sync[1];
    assign go_lvl  = go_sync[1];
    assign stb     = stb_sync[1] & ~stb_last;
    assign go      = go_sync[1] & ~go_last;

    // Burst auto-increment touches only the word index and wraps inside the selected target.
    assign addr_inc = {addr_q[ADDR_W-1:IDX_W], addr_q[IDX_W-1:0] + IDX_W'(1)};

    // Protocol FSM; all pad and memory outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            burst_q        <= 1'b0;
            addr_q         <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            scan_data_out  <= '0;
            scan_data_oe   <= 1'b0;
            data_out_valid <= 1'b0;
            exec_run       <= 1'b0;
            exec_end       <= 1'b0;
            scan_err       <= 1'b0;
        end else begin
            mem_addr <= addr_q;
            if (!chip_en) begin
                // Disabled: drop every active handshake but keep the address and the error flag.
                state          <= ST_IDLE;
                mem_req        <= 1'b0;
                mem_we         <= 1'b0;
                exec_run       <= 1'b0;
                data_out_valid <= 1'b0;
                scan_data_oe   <= 1'b0;
                exec_end       <= 1'b0;
                if (stb && !scan_data_or_addr) begin
                    scan_err <= 1'b1;
                end
            end else begin
                if (stb && state != ST_IDLE) begin
                    scan_err <= 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        // A strobe takes priority; a simultaneous exec edge is lost.
                        if (stb) begin
                            burst_q <= data_addr_valid[1];
                            if (scan_data_or_addr) begin
                                addr_q   <= scan_data_in;
                                scan_err <= 1'b0;
                            end else if (read_write) begin
                                mem_wdata <= scan_data_in;
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                state     <= ST_WR_REQ;
                            end else begin
                                mem_req <= 1'b1;
                                mem_we  <= 1'b0;
                                state   <= ST_RD_REQ;
                            end
                        end else if (go) begin
                            exec_run <= 1'b1;
                            state    <= ST_EXEC;
                        end
                    end
                    ST_WR_REQ: begin
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            state   <= ST_IDLE;
                            if (burst_q) begin
                                addr_q <= addr_inc;
                            end
                        end
                    end
                    ST_RD_REQ: begin
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            state   <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (mem_rvalid) begin
                            scan_data_out  <= mem_rdata;
                            data_out_valid <= 1'b1;
                            scan_data_oe   <= 1'b1;
                            state          <= ST_RD_HOLD;
                        end
                    end
                    ST_RD_HOLD: begin
                        // Read data stays on the pads until the host releases its strobe.
                        if (!stb_lvl) begin
                            data_out_valid <= 1'b0;
                            scan_data_oe   <= 1'b0;
                            state          <= ST_IDLE;
                            if (burst_q) begin
                                addr_q <= addr_inc;
                            end
                        end
                    end
                    ST_EXEC: begin
                        if (exec_done) begin
                            exec_run <= 1'b0;
                            exec_end <= 1'b1;
                            state    <= ST_EXEC_END;
                        end
                    end
                    ST_EXEC_END: begin
                        if (!go_lvl) begin
                            exec_end <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_port_ctrl.sv
// tb/tb_scan_port_ctrl.sv - self-checking bench for scan_port_ctrl
module tb_scan_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        chip_en;
    logic [15:0] scan_data_in;
    logic        scan_data_or_addr;
    logic        read_write;
    logic [1:0]  data_addr_valid;
    logic        scan_start_exec;
    logic [15:0] scan_data_out;
    logic        scan_data_oe;
    logic        data_out_valid;
    logic        exec_end;
    logic        scan_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        exec_run;
    logic        exec_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic        we;
    } txn_t;

    txn_t        txn_log[$];
    logic [15:0] mem_model [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] exp_addr;
    int          rd_delay = 2;
    int          gnt_bias = 0;
    int          rd_cnt = 0;
    logic [15:0] rd_addr;

    always #5 clk = ~clk;

    scan_port_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .chip_en           (chip_en),
        .scan_data_in      (scan_data_in),
        .scan_data_or_addr (scan_data_or_addr),
        .read_write        (read_write),
        .data_addr_valid   (data_addr_valid),
        .scan_start_exec   (scan_start_exec),
        .scan_data_out     (scan_data_out),
        .scan_data_oe      (scan_data_oe),
        .data_out_valid    (data_out_valid),
        .exec_end          (exec_end),
        .scan_err          (scan_err),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_gnt           (mem_gnt),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .exec_run          (exec_run),
        .exec_done         (exec_done)
    );

    // Memory responder: random grant delay, read data a programmable number of cycles after grant.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (reset) begin
            mem_gnt = 1'b0;
            rd_cnt  = 0;
        end else begin
            if (rd_cnt > 0) begin
                rd_cnt = rd_cnt - 1;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_model.exists(rd_addr) ? mem_model[rd_addr] : 16'hDEAD;
                end
            end
            if (mem_gnt) begin
                mem_gnt = 1'b0;
            end else if (mem_req && $urandom_range(0, gnt_bias) == 0) begin
                mem_gnt = 1'b1;
                txn_log.push_back('{a: mem_addr, d: mem_wdata, we: mem_we});
                if (mem_we) begin
                    mem_model[mem_addr] = mem_wdata;
                end else begin
                    rd_addr = mem_addr;
                    rd_cnt  = rd_delay;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] next_addr(input logic [15:0] a);
        logic [11:0] idx;
        idx = a[11:0] + 12'd1;
        return {a[15:12], idx};
    endfunction

    task automatic pad_raise(input logic is_addr, input logic wr, input logic burst, input logic [15:0] d);
        @(negedge clk);
        scan_data_in       = d;
        scan_data_or_addr  = is_addr;
        read_write         = wr;
        data_addr_valid[1] = burst;
        data_addr_valid[0] = 1'b1;
    endtask

    task automatic pad_drop();
        @(negedge clk);
        data_addr_valid = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_txn(input string tag, output txn_t t, output bit ok);
        int n = 0;
        while (txn_log.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (txn_log.size() != 0);
        chk({tag, "_seen"}, 64'(ok), 64'd1);
        if (ok) t = txn_log.pop_front();
    endtask

    task automatic do_addr(input logic [15:0] a);
        pad_raise(1'b1, 1'b0, 1'b0, a);
        repeat (4) @(negedge clk);
        pad_drop();
        exp_addr = a;
    endtask

    task automatic do_write(input logic [15:0] d, input logic burst);
        txn_t t;
        bit   ok;
        pad_raise(1'b0, 1'b1, burst, d);
        wait_txn("wr", t, ok);
        if (ok) begin
            chk("wr_addr", 64'(t.a), 64'(exp_addr));
            chk("wr_data", 64'(t.d), 64'(d));
            chk("wr_we", 64'(t.we), 64'd1);
        end
        ref_mem[exp_addr] = d;
        if (burst) exp_addr = next_addr(exp_addr);
        pad_drop();
        chk("wr_req_idle", 64'(mem_req), 64'd0);
    endtask

    task automatic do_read(input logic burst);
        txn_t        t;
        bit          ok;
        int          n;
        logic [15:0] v;
        if (!ref_mem.exists(exp_addr)) begin
            v = 16'($urandom);
            ref_mem[exp_addr]   = v;
            mem_model[exp_addr] = v;
        end
        pad_raise(1'b0, 1'b0, burst, 16'h0000);
        wait_txn("rd", t, ok);
        if (ok) begin
            chk("rd_addr", 64'(t.a), 64'(exp_addr));
            chk("rd_we", 64'(t.we), 64'd0);
        end
        n = 0;
        while (!data_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd_valid", 64'(data_out_valid), 64'd1);
        chk("rd_data", 64'(scan_data_out), 64'(ref_mem[exp_addr]));
        repeat (3) @(negedge clk);
        chk("rd_hold", {62'd0, data_out_valid, scan_data_oe}, 64'd3);
        data_addr_valid[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (data_out_valid && n < 10);
        chk("rd_fall_lat", 64'(n), 64'd3);
        chk("rd_oe_off", 64'(scan_data_oe), 64'd0);
        if (burst) exp_addr = next_addr(exp_addr);
        data_addr_valid = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        txn_t t;
        bit   ok;
        int   n;
        int   run_cnt;
        bit   saw;

        reset             = 1'b1;
        chip_en           = 1'b1;
        scan_data_in      = 16'h0000;
        scan_data_or_addr = 1'b0;
        read_write        = 1'b0;
        data_addr_valid   = 2'b00;
        scan_start_exec   = 1'b0;
        exec_done         = 1'b0;
        mem_gnt           = 1'b0;
        mem_rvalid        = 1'b0;
        mem_rdata         = 16'h0000;
        exp_addr          = 16'h0000;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_outs", {scan_data_out, scan_data_oe, data_out_valid, exec_end, scan_err,
                           mem_req, mem_we, mem_addr, mem_wdata, exec_run}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_outs", {scan_data_out, scan_data_oe, data_out_valid, exec_end, scan_err,
                                mem_req, mem_we, mem_addr, mem_wdata, exec_run}, 64'd0);

        // Single write, then a second write proves the address did not move
        do_addr(16'h2010);
        do_write(16'hBEEF, 1'b0);
        chk("addr_kept", 64'(exp_addr), 64'h2010);
        do_write(16'hCAFE, 1'b0);

        // Burst writes across the index wrap
        gnt_bias = 2;
        do_addr(16'h1FFF);
        do_write(16'h0001, 1'b1);
        chk("wrap_addr", 64'(exp_addr), 64'h1000);
        do_write(16'h0002, 1'b1);

        // Read with data two cycles after grant
        gnt_bias = 0;
        rd_delay = 2;
        mem_model[16'h3005] = 16'hA5A5;
        ref_mem[16'h3005]   = 16'hA5A5;
        do_addr(16'h3005);
        do_read(1'b0);
        chk("rd_a5a5", 64'(scan_data_out), 64'hA5A5);

        // Execution, with a data strobe arriving while running
        @(negedge clk);
        scan_start_exec = 1'b1;
        n = 0;
        while (!exec_run && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("exec_run_rise", 64'(exec_run), 64'd1);
        run_cnt = 1;
        saw = 1'b0;
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            if (i == 5) begin
                scan_data_in      = 16'h1111;
                scan_data_or_addr = 1'b0;
                read_write        = 1'b1;
                data_addr_valid   = 2'b01;
            end
            if (i == 15) data_addr_valid = 2'b00;
            if (exec_run) run_cnt++;
            if (mem_req) saw = 1'b1;
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("exec_run_cycles", 64'(run_cnt), 64'd50);
        chk("exec_run_fall", {62'd0, exec_run, exec_end}, 64'd1);
        chk("exec_strobe_noreq", 64'(saw), 64'd0);
        chk("exec_strobe_err", 64'(scan_err), 64'd1);
        chk("exec_no_txn", 64'(txn_log.size()), 64'd0);
        repeat (5) @(negedge clk);
        chk("exec_end_hold", 64'(exec_end), 64'd1);
        scan_start_exec = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (exec_end && n < 10);
        chk("exec_end_fall_lat", 64'(n), 64'd3);
        do_addr(16'h4000);
        chk("err_cleared", 64'(scan_err), 64'd0);

        // Strobe and exec request rising together: the write wins
        @(negedge clk);
        scan_data_in      = 16'h5A5A;
        scan_data_or_addr = 1'b0;
        read_write        = 1'b1;
        data_addr_valid   = 2'b01;
        scan_start_exec   = 1'b1;
        saw = 1'b0;
        wait_txn("tie", t, ok);
        if (ok) begin
            chk("tie_addr", 64'(t.a), 64'h4000);
            chk("tie_data", 64'(t.d), 64'h5A5A);
        end
        ref_mem[16'h4000] = 16'h5A5A;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (exec_run) saw = 1'b1;
        end
        chk("tie_no_exec", 64'(saw), 64'd0);
        data_addr_valid = 2'b00;
        scan_start_exec = 1'b0;
        repeat (5) @(negedge clk);

        // Data strobe with the block disabled
        chip_en = 1'b0;
        pad_raise(1'b0, 1'b1, 1'b0, 16'h7777);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_req) saw = 1'b1;
        end
        pad_drop();
        chk("dis_noreq", 64'(saw), 64'd0);
        chk("dis_err", 64'(scan_err), 64'd1);
        chip_en = 1'b1;
        do_addr(16'h4001);
        chk("dis_err_clear", 64'(scan_err), 64'd0);

        // Reset while waiting for read data
        mem_model[16'h0123] = 16'h1357;
        ref_mem[16'h0123]   = 16'h1357;
        do_addr(16'h0123);
        rd_delay = 20;
        pad_raise(1'b0, 1'b0, 1'b0, 16'h0000);
        wait_txn("rst_rd", t, ok);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_mid_outs", {scan_data_out, scan_data_oe, data_out_valid, exec_end, scan_err,
                               mem_req, mem_we, mem_addr, mem_wdata, exec_run}, 64'd0);
        data_addr_valid = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        txn_log.delete();
        exp_addr = 16'h0000;
        rd_delay = 2;
        repeat (2) @(negedge clk);
        do_addr(16'h0123);
        do_read(1'b0);

        // Randomized host traffic against the reference model
        for (int k = 0; k < 24; k++) begin
            gnt_bias = $urandom_range(0, 3);
            rd_delay = $urandom_range(1, 4);
            case ($urandom_range(0, 3))
                0: begin
                    if ($urandom_range(0, 1) == 1)
                        do_addr({4'($urandom_range(0, 15)), 12'($urandom_range(4093, 4095))});
                    else
                        do_addr(16'($urandom));
                end
                1, 2: do_write(16'($urandom), 1'($urandom_range(0, 1)));
                default: do_read(1'($urandom_range(0, 1)));
            endcase
        end
        chk("final_no_err", 64'(scan_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_port_ctrl.md
# scan_port_ctrl

On-chip protocol engine between the pad-level scan port and the CGRA array. It decodes host strobes on the 16-bit scan bus into address loads, memory writes and memory reads; returns read data with a valid/acknowledge handshake; and sequences array execution from scan_start_exec through exec_end. It sits inside chip, directly behind the pad receivers, and is the only master of the array memory port while the array is idle.

## Interface
- ADDR_W, 16, width of the scan address register; bits [15:12] are the target select, bits [11:0] the word index.
- DATA_W, 16, width of the scan and memory data words.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- chip_en  in  1  block enable; low forces IDLE and blocks strobes.
- scan_data_in  in  16  host word.
- scan_data_or_addr  in  1  1 = address word, 0 = data word.
- read_write  in  1  1 = write, 0 = read (data words only).
- data_addr_valid  in  2  [0] = word strobe (level, asynchronous); [1] = burst (auto-increment).
- scan_start_exec  in  1  asynchronous execution request (level).
- scan_data_out  out  16  read data to pads.
- scan_data_oe  out  1  pad output enable for scan_data_out.
- data_out_valid  out  1  read data valid.
- exec_end  out  1  execution complete.
- scan_err  out  1  sticky protocol error.
- mem_req, mem_we  out  1  memory request and write-enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  16  read data.
- exec_run  out  1  array run enable.
- exec_done  in  1  single-cycle array completion pulse.

## Operation
- data_addr_valid[0] and scan_start_exec each pass through a 2-flop synchronizer plus an edge flop. The rising edge yields a one-cycle strobe (stb, go). scan_data_in, scan_data_or_addr, read_write and data_addr_valid[1] are sampled only in the stb cycle; the host holds them stable while the strobe is high.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_HOLD, EXEC, EXEC_END.
- IDLE + stb + addr word: load addr_q ← scan_data_in, clear scan_err, stay in IDLE.
- IDLE + stb + data + write: latch wdata, go to WR_REQ.
- IDLE + stb + data + read: go to RD_REQ.
- WR_REQ: mem_req=1, mem_we=1 until mem_gnt. On the grant cycle, go to IDLE. If burst, addr_q[11:0] increments.
- RD_REQ: mem_req=1, mem_we=0 until mem_gnt, then go to RD_WAIT.
- RD_WAIT: on mem_rvalid, capture mem_rdata into scan_data_out, go to RD_HOLD.
- RD_HOLD: data_out_valid=1 and scan_data_oe=1. Exit to IDLE when synchronized data_addr_valid[0] is low, then clear both outputs. If burst, increment.
- Burst increment wraps addr_q[11:0] from 0xFFF to 0x000; addr_q[15:12] is never modified.
- IDLE + go: exec_run=1, go to EXEC. On exec_done, exec_run=0 and go to EXEC_END.
- EXEC_END: exec_end=1. Exit to IDLE when synchronized scan_start_exec is low.
- In IDLE, stb and go in the same cycle: stb wins. go is dropped and the host must re-raise scan_start_exec.
- stb in any non-IDLE state is ignored and sets scan_err. go outside IDLE is ignored without error.
- A data strobe with chip_en low is ignored and sets scan_err.
- chip_en low forces IDLE synchronously and deasserts mem_req, exec_run, data_out_valid, scan_data_oe and exec_end. addr_q and scan_err are retained.

## Timing
- Reset values: all outputs 0, addr_q=0, FSM in IDLE, synchronizers 0.
- Pad strobe rise to stb: 3 clk rising edges. mem_req is asserted the cycle after stb.
- Write: mem_req is held until and including the mem_gnt cycle; FSM is in IDLE the next cycle.
- Read: data_out_valid rises the cycle after mem_rvalid. It falls 3 cycles after the pad strobe falls (2 synchronizer cycles + 1 registered output), including the FSM transition.
- mem_addr = addr_q, registered. It is stable for the whole request.
- exec_run rises 1 cycle after go and falls the cycle after exec_done.
- exec_end rises the same cycle exec_run falls.
- Asynchronous reset mid-transaction: immediate return to reset values. Any pending memory transaction is abandoned; the memory side tolerates a dropped mem_req.

## Test plan
- Address 0x2010, then write 0xBEEF, no burst: one mem_req/mem_we with addr 0x2010 and wdata 0xBEEF; addr_q stays 0x2010.
- Address 0x1FFF, burst writes 0x0001 and 0x0002: writes to 0x1FFF then 0x1000 (wrap; target 0x1 kept).
- Read at 0x3005, memory returns 0xA5A5 two cycles after grant: scan_data_out=0xA5A5, data_out_valid and oe held until the strobe drops, cleared 3 cycles later.
- Raise scan_start_exec, pulse exec_done after 50 cycles: exec_run high for 50 cycles, exec_end high until scan_start_exec drops. A data strobe during EXEC gives no mem_req and scan_err=1; a subsequent address strobe clears scan_err.
- Strobe and scan_start_exec arrive in the same cycle: the write is performed, exec_run stays 0.
- Assert reset during RD_WAIT: all outputs go to 0 immediately; a new read after reset completes normally.
